ofs_fim_pcie_ss_rx_sb2ib: RTL and testbench
===========================================

// Module: ofs_fim_pcie_ss_rx_sb2ib
// PURPOSE
//  RX counterpart of the TX side-band header path: converts a PCIe SS RX AXI-S stream with side-band
//  headers (tuser hdr/hvalid) into the OFS FIM in-band format, where the 256-bit header occupies
//  tdata[255:0] of the SOP beat and payload follows. Sits after the HIP->FIM clock crossing, in fim_clk.
//  Realigns payload by 256 bits across beats; inserts a flush beat when residue remains at EOP.
// PARAMETERS
//  TDATA_WIDTH  512        data width; multiple of 256, >= 512
//  TKEEP_WIDTH  TDATA_WIDTH/8  byte enables
//  USER_W       1          output tuser_vendor width; bit 0 = vendor bit, others driven 0
//  HDR_WIDTH    256        header width (localparam; HB = HDR_WIDTH/8 = 32 bytes)
// PORTS
//  clk                  in   1           fim clock
//  rst                  in   1           synchronous, active-high reset
//  ss_rx_tvalid         in   1           side-band input valid
//  ss_rx_tready         out  1           input ready
//  ss_rx_tdata          in   TDATA_WIDTH payload only, starts at bit 0 on SOP
//  ss_rx_tkeep          in   TKEEP_WIDTH payload byte enables (all 0 on header-only packet)
//  ss_rx_tlast          in   1           end of packet
//  ss_rx_tuser_vendor   in   1           vendor bit
//  ss_rx_tuser_hvalid   in   1           header valid; required exactly on SOP beats
//  ss_rx_tuser_hdr      in   256         PCIe SS header
//  ib_rx                pcie_ss_axis_if.source  in-band output (DATA_W=TDATA_WIDTH, USER_W)
//  err_hdr              out  1           sticky: hvalid on non-SOP beat or SOP beat without hvalid
// BEHAVIOUR
//  - Reset: ib_rx.tvalid=0, err_hdr=0, residue cleared, state=SOP. Reset mid-packet abandons the packet.
//  - Output is a single registered stage: 1-cycle latency; accept when ss_rx_tready && tvalid.
//  - ss_rx_tready = (state!=FLUSH) && (!ib_rx.tvalid || ib_rx.tready).
//  - Beat mapping (W=TDATA_WIDTH, K=TKEEP_WIDTH):
//    SOP: out.tdata={in.tdata[W-257:0], hdr}; out.tkeep={in.tkeep[K-33:0], 32'hFFFF_FFFF};
//    MID: out.tdata={in.tdata[W-257:0], res_data}; out.tkeep={in.tkeep[K-33:0], res_keep};
//    every accepted beat loads res_data=in.tdata[W-1 -: 256], res_keep=in.tkeep[K-1 -: 32].
//  - tuser_vendor: latched from SOP beat; out bit0 = latched vendor on all beats of packet.
//  - States: SOP -> (accept SOP, !tlast) -> MID; MID -> (accept tlast) -> SOP or FLUSH.
//    On tlast accept: if new res_keep!=0 -> FLUSH with out.tlast=0; else out.tlast=1, -> SOP.
//    SOP beat with tlast follows the same rule (single-beat packet may need FLUSH).
//    FLUSH: when output register free, emit tdata={0,res_data}, tkeep={0,res_keep}, tlast=1, -> SOP.
//  - Header-only (tkeep=0, tlast=1): one output beat, tkeep low 32 bytes only, tlast=1.
//  - Error: hvalid=1 in MID -> beat treated as MID data, header discarded, err_hdr set.
//    hvalid=0 in SOP -> beat dropped (accepted, not forwarded), err_hdr set, state unchanged
//    unless tlast=0 (then subsequent beats dropped until tlast). err_hdr clears only on rst.
//  - Backpressure: output holds tdata/tkeep/tlast/tvalid stable while tvalid && !tready.
//  - Throughput: 1 beat/cycle; one input bubble per packet only when FLUSH is required.
// STRUCTURE
//  - ofs_fim_pcie_ss_shims_pkg: HDR_WIDTH/HB constants, t_rx_sb2ib_state enum {SOP,MID,FLUSH,DROP}.
//  - Single module, no sub-modules; output register is inline (skid not needed, ready is combinational
//    from output stage only). ~200 lines.
// TESTING
//  - 512b, single-beat header-only (tkeep=0,tlast) -> one beat, tkeep=64'h0000_0000_FFFF_FFFF, tlast=1, tdata[255:0]=hdr.
//  - 512b, 32B payload 0xA5.. one beat -> one out beat, tkeep=64'hFFFF_FFFF_FFFF_FFFF, tlast=1, no FLUSH.
//  - 512b, 64B payload one beat -> two out beats: hdr+low 32B, then upper 32B tkeep=64'h0000_0000_FFFF_FFFF tlast; ss_rx_tready=0 one cycle.
//  - 512b, 128B payload 2 beats with ib_rx.tready random 50% -> 3 beats, byte-exact payload, no drops/dups, stable under stall.
//  - hvalid=1 on second beat of a 2-beat packet -> data forwarded unchanged, err_hdr=1 thereafter; SOP beat hvalid=0 -> dropped, err_hdr=1.
//  - rst asserted mid-packet (MID, out stalled) -> next cycle tvalid=0, state SOP; next packet converts correctly.

Source files
------------

// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
// ----------------------------------------------------------------------------
// ofs_fim_pcie_ss_shims_pkg
//  Shared constants and types for the PCIe SS side-band/in-band shims.
//  HDR_WIDTH : width of the PCIe SS TLP header carried in-band (bits)
//  HB        : the same header width in bytes
//  t_rx_sb2ib_state : packet-tracking state of the RX side-band to in-band shim
// ----------------------------------------------------------------------------
package ofs_fim_pcie_ss_shims_pkg;

    localparam int HDR_WIDTH = 256;
    localparam int HB        = HDR_WIDTH / 8;

    typedef enum logic [1:0] {
        SOP   = 2'd0,   // waiting for the header beat of a packet
        MID   = 2'd1,   // inside a packet, forwarding payload beats
        FLUSH = 2'd2,   // emitting the leftover residue after EOP
        DROP  = 2'd3    // discarding a packet whose SOP had no header
    } t_rx_sb2ib_state;

endpackage

// File: rtl/pcie_ss_axis_if.sv
// ----------------------------------------------------------------------------
// pcie_ss_axis_if
//  AXI-Stream bundle used for the in-band PCIe SS stream.
//  tvalid/tready : handshake
//  tdata/tkeep   : data bus and byte enables (DATA_W / DATA_W/8)
//  tlast         : end of packet
//  tuser_vendor  : vendor side-band bits (USER_W)
//  Modports: source/master drive the stream, sink/slave receive it.
// ----------------------------------------------------------------------------
interface pcie_ss_axis_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 1
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic [USER_W-1:0]     tuser_vendor;

    modport source (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
    modport sink   (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
    modport master (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
endinterface

// File: rtl/ofs_fim_pcie_ss_rx_sb2ib.sv
// ----------------------------------------------------------------------------
// ofs_fim_pcie_ss_rx_sb2ib
//  Converts a PCIe SS RX AXI-S stream carrying the TLP header in side-band
//  (tuser hdr/hvalid) into the in-band format: the 256-bit header sits in
//  tdata[255:0] of the SOP beat and the payload is shifted up by 256 bits.
//  Payload that spills past the last input beat is emitted as an extra
//  flush beat.
//  Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ss_rx_*             : side-band input stream (payload from bit 0 on SOP)
//   ib_rx               : in-band output stream (single register stage)
//   err_hdr             : sticky header-framing error flag
// ----------------------------------------------------------------------------
module ofs_fim_pcie_ss_rx_sb2ib
    import ofs_fim_pcie_ss_shims_pkg::*;
#(
    parameter int TDATA_WIDTH = 512,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int USER_W      = 1
)(
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ss_rx_tvalid,
    output logic                    ss_rx_tready,
    input  logic [TDATA_WIDTH-1:0]  ss_rx_tdata,
    input  logic [TKEEP_WIDTH-1:0]  ss_rx_tkeep,
    input  logic                    ss_rx_tlast,
    input  logic                    ss_rx_tuser_vendor,
    input  logic                    ss_rx_tuser_hvalid,
    input  logic [HDR_WIDTH-1:0]    ss_rx_tuser_hdr,

    pcie_ss_axis_if.source          ib_rx,

    output logic                    err_hdr
);

    localparam int W = TDATA_WIDTH;
    localparam int K = TKEEP_WIDTH;

    t_rx_sb2ib_state        state_reg, state_next;

    logic                   out_valid_reg, out_valid_next;
    logic [W-1:0]           out_data_reg, out_data_next;
    logic [K-1:0]           out_keep_reg, out_keep_next;
    logic                   out_last_reg, out_last_next;
    logic                   out_vendor_reg, out_vendor_next;

    // Upper 256 bits of the previous beat, waiting to be placed in the
    // low half of the next output beat.
    logic [HDR_WIDTH-1:0]   res_data_reg, res_data_next;
    logic [HB-1:0]          res_keep_reg, res_keep_next;

    logic                   vendor_reg, vendor_next;
    logic                   err_reg, err_next;

    logic                   out_free;
    logic                   accept;
    logic                   fwd;
    logic [HDR_WIDTH-1:0]   lower_data;
    logic [HB-1:0]          lower_keep;
    logic [USER_W-1:0]      user_vec;

    assign out_free     = !out_valid_reg || ib_rx.tready;
    assign ss_rx_tready = (state_reg != FLUSH) && out_free;
    assign accept       = ss_rx_tvalid && ss_rx_tready;

    always_comb begin
        state_next      = state_reg;
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_keep_next   = out_keep_reg;
        out_last_next   = out_last_reg;
        out_vendor_next = out_vendor_reg;
        res_data_next   = res_data_reg;
        res_keep_next   = res_keep_reg;
        vendor_next     = vendor_reg;
        err_next        = err_reg;
        fwd             = 1'b0;
        lower_data      = res_data_reg;
        lower_keep      = res_keep_reg;

        if (out_free) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            SOP: begin
                if (accept) begin
                    if (ss_rx_tuser_hvalid) begin
                        fwd         = 1'b1;
                        lower_data  = ss_rx_tuser_hdr;
                        lower_keep  = '1;
                        vendor_next = ss_rx_tuser_vendor;
                    end else begin
                        // Headerless SOP: swallow the whole packet.
                        err_next = 1'b1;
                        if (!ss_rx_tlast) begin
                            state_next = DROP;
                        end
                    end
                end
            end
            MID: begin
                if (accept) begin
                    fwd = 1'b1;
                    if (ss_rx_tuser_hvalid) begin
                        err_next = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    out_valid_next  = 1'b1;
                    out_data_next   = {{(W-HDR_WIDTH){1'b0}}, res_data_reg};
                    out_keep_next   = {{(K-HB){1'b0}}, res_keep_reg};
                    out_last_next   = 1'b1;
                    out_vendor_next = vendor_reg;
                    res_keep_next   = '0;
                    state_next      = SOP;
                end
            end
            DROP: begin
                if (accept) begin
                    if (ss_rx_tuser_hvalid) begin
                        err_next = 1'b1;
                    end
                    if (ss_rx_tlast) begin
                        state_next = SOP;
                    end
                end
            end
            default: state_next = SOP;
        endcase

        // Common path for every forwarded beat (header beat or payload beat).
        if (fwd) begin
            out_valid_next  = 1'b1;
            out_data_next   = {ss_rx_tdata[W-HDR_WIDTH-1:0], lower_data};
            out_keep_next   = {ss_rx_tkeep[K-HB-1:0], lower_keep};
            out_vendor_next = vendor_next;
            res_data_next   = ss_rx_tdata[W-1 -: HDR_WIDTH];
            res_keep_next   = ss_rx_tkeep[K-1 -: HB];
            if (ss_rx_tlast && (res_keep_next != '0)) begin
                // Bytes remain past this beat: EOP moves to the flush beat.
                out_last_next = 1'b0;
                state_next    = FLUSH;
            end else if (ss_rx_tlast) begin
                out_last_next = 1'b1;
                state_next    = SOP;
            end else begin
                out_last_next = 1'b0;
                state_next    = MID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= SOP;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_keep_reg   <= '0;
            out_last_reg   <= 1'b0;
            out_vendor_reg <= 1'b0;
            res_data_reg   <= '0;
            res_keep_reg   <= '0;
            vendor_reg     <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_keep_reg   <= out_keep_next;
            out_last_reg   <= out_last_next;
            out_vendor_reg <= out_vendor_next;
            res_data_reg   <= res_data_next;
            res_keep_reg   <= res_keep_next;
            vendor_reg     <= vendor_next;
            err_reg        <= err_next;
        end
    end

    // Only bit 0 of the output user field carries the vendor bit.
    always_comb begin
        user_vec    = '0;
        user_vec[0] = out_vendor_reg;
    end

    assign ib_rx.tvalid       = out_valid_reg;
    assign ib_rx.tdata        = out_data_reg;
    assign ib_rx.tkeep        = out_keep_reg;
    assign ib_rx.tlast        = out_last_reg;
    assign ib_rx.tuser_vendor = user_vec;
    assign err_hdr            = err_reg;

endmodule

// File: tb/tb_ofs_fim_pcie_ss_rx_sb2ib.sv
// ----------------------------------------------------------------------------
// tb_ofs_fim_pcie_ss_rx_sb2ib
//  Directed bench for the RX side-band to in-band shim at 512 bits.
//  Inputs change on the falling edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_ofs_fim_pcie_ss_rx_sb2ib;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic         u;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ss_rx_tvalid = 1'b0;
    logic         ss_rx_tready;
    logic [511:0] ss_rx_tdata = '0;
    logic [63:0]  ss_rx_tkeep = '0;
    logic         ss_rx_tlast = 1'b0;
    logic         ss_rx_tuser_vendor = 1'b0;
    logic         ss_rx_tuser_hvalid = 1'b0;
    logic [255:0] ss_rx_tuser_hdr = '0;
    logic         err_hdr;

    pcie_ss_axis_if #(.DATA_W(512), .USER_W(1)) ib_rx ();

    ofs_fim_pcie_ss_rx_sb2ib #(
        .TDATA_WIDTH (512),
        .TKEEP_WIDTH (64),
        .USER_W      (1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ss_rx_tvalid       (ss_rx_tvalid),
        .ss_rx_tready       (ss_rx_tready),
        .ss_rx_tdata        (ss_rx_tdata),
        .ss_rx_tkeep        (ss_rx_tkeep),
        .ss_rx_tlast        (ss_rx_tlast),
        .ss_rx_tuser_vendor (ss_rx_tuser_vendor),
        .ss_rx_tuser_hvalid (ss_rx_tuser_hvalid),
        .ss_rx_tuser_hdr    (ss_rx_tuser_hdr),
        .ib_rx              (ib_rx),
        .err_hdr            (err_hdr)
    );

    always #5 clk = ~clk;

    int    compared   = 0;
    int    mismatched = 0;
    beat_t q[$];
    int    stall_err  = 0;
    int    nready_cnt = 0;
    logic  rand_en    = 1'b0;
    logic  ready_force = 1'b1;

    // Output ready driver: changes shortly after the rising edge.
    initial begin
        ib_rx.tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ib_rx.tready = rand_en ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Output monitor: collects accepted beats and checks stall stability.
    logic         prev_stall = 1'b0;
    logic [511:0] stall_d;
    logic [63:0]  stall_k;
    logic         stall_l;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (ib_rx.tvalid !== 1'b1 || ib_rx.tdata !== stall_d ||
                               ib_rx.tkeep !== stall_k || ib_rx.tlast !== stall_l))
                stall_err++;
            if (ib_rx.tvalid && ib_rx.tready) begin
                q.push_back('{d: ib_rx.tdata, k: ib_rx.tkeep, l: ib_rx.tlast, u: ib_rx.tuser_vendor[0]});
                $display("[%0t] out beat keep=%h last=%0d vendor=%0d", $time, ib_rx.tkeep, ib_rx.tlast, ib_rx.tuser_vendor[0]);
            end
            if (!ss_rx_tready) nready_cnt++;
            prev_stall = ib_rx.tvalid && !ib_rx.tready;
            stall_d = ib_rx.tdata;
            stall_k = ib_rx.tkeep;
            stall_l = ib_rx.tlast;
        end
    end

    function automatic logic [511:0] pat(input logic [7:0] base);
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[8*i +: 8] = base + 8'(i);
        return r;
    endfunction

    // Present one input beat and hold it until accepted; called at a falling edge.
    task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l,
                        input logic hv, input logic [255:0] h, input logic v);
        int n;
        ss_rx_tvalid = 1'b1;
        ss_rx_tdata = d;
        ss_rx_tkeep = k;
        ss_rx_tlast = l;
        ss_rx_tuser_hvalid = hv;
        ss_rx_tuser_hdr = h;
        ss_rx_tuser_vendor = v;
        n = 0;
        while (!ss_rx_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 200) begin
            mismatched++;
            $display("FAIL send_timeout: input not accepted after %0d cycles, required < 200", n);
        end
        @(posedge clk);
        $display("[%0t] in beat keep=%h last=%0d hvalid=%0d", $time, k, l, hv);
        @(negedge clk);
        ss_rx_tvalid = 1'b0;
        ss_rx_tuser_hvalid = 1'b0;
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    logic [255:0] hdr_a, hdr_b, hdr_c;

    task automatic test_reset();
        do_reset();
        compared++;
        if (ib_rx.tvalid !== 1'b0) begin mismatched++; $display("FAIL reset_tvalid: got %b want 0", ib_rx.tvalid); end
        compared++;
        if (err_hdr !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", err_hdr); end
        compared++;
        if (ss_rx_tready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", ss_rx_tready); end
    endtask

    task automatic test_hdr_only();
        q.delete();
        send('0, 64'h0, 1'b1, 1'b1, hdr_a, 1'b1);
        drain(6);
        compared++;
        if (q.size() !== 1) begin mismatched++; $display("FAIL hdr_only_count: got %0d want 1", q.size()); end
        if (q.size() >= 1) begin
            compared++;
            if (q[0].d !== {256'h0, hdr_a}) begin mismatched++; $display("FAIL hdr_only_data: got %h want %h", q[0].d, {256'h0, hdr_a}); end
            compared++;
            if (q[0].k !== 64'h0000_0000_FFFF_FFFF) begin mismatched++; $display("FAIL hdr_only_keep: got %h want 00000000ffffffff", q[0].k); end
            compared++;
            if (q[0].l !== 1'b1 || q[0].u !== 1'b1) begin mismatched++; $display("FAIL hdr_only_last_user: got %b%b want 11", q[0].l, q[0].u); end
        end
    endtask

    task automatic test_32b();
        logic [255:0] a5;
        a5 = {32{8'hA5}};
        q.delete();
        nready_cnt = 0;
        send({256'h0, a5}, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, hdr_b, 1'b0);
        drain(6);
        compared++;
        if (q.size() !== 1) begin mismatched++; $display("FAIL b32_count: got %0d want 1", q.size()); end
        if (q.size() >= 1) begin
            compared++;
            if (q[0].d !== {a5, hdr_b}) begin mismatched++; $display("FAIL b32_data: got %h want %h", q[0].d, {a5, hdr_b}); end
            compared++;
            if (q[0].k !== 64'hFFFF_FFFF_FFFF_FFFF || q[0].l !== 1'b1) begin mismatched++; $display("FAIL b32_keep_last: got %h/%b want ffffffffffffffff/1", q[0].k, q[0].l); end
        end
        compared++;
        if (nready_cnt !== 0) begin mismatched++; $display("FAIL b32_no_flush: ready low %0d cycles, want 0", nready_cnt); end
    endtask

    task automatic test_64b();
        logic [511:0] p;
        p = pat(8'h00);
        q.delete();
        nready_cnt = 0;
        send(p, '1, 1'b1, 1'b1, hdr_c, 1'b1);
        drain(6);
        compared++;
        if (q.size() !== 2) begin mismatched++; $display("FAIL b64_count: got %0d want 2", q.size()); end
        if (q.size() >= 2) begin
            compared++;
            if (q[0].d !== {p[255:0], hdr_c} || q[0].k !== '1 || q[0].l !== 1'b0) begin
                mismatched++; $display("FAIL b64_beat0: got k=%h l=%b d=%h want k=all-ones l=0", q[0].k, q[0].l, q[0].d);
            end
            compared++;
            if (q[1].d !== {256'h0, p[511:256]} || q[1].k !== 64'h0000_0000_FFFF_FFFF || q[1].l !== 1'b1) begin
                mismatched++; $display("FAIL b64_flush: got k=%h l=%b d=%h want k=00000000ffffffff l=1", q[1].k, q[1].l, q[1].d);
            end
            compared++;
            if (q[1].u !== 1'b1) begin mismatched++; $display("FAIL b64_flush_vendor: got %b want 1", q[1].u); end
        end
        compared++;
        if (nready_cnt !== 1) begin mismatched++; $display("FAIL b64_ready_bubble: ready low %0d cycles, want 1", nready_cnt); end
    endtask

    task automatic test_back_to_back_stall();
        logic [511:0] p0, p1;
        p0 = pat(8'h10);
        p1 = pat(8'h80);
        q.delete();
        stall_err = 0;
        rand_en = 1'b1;
        send(p0, '1, 1'b0, 1'b1, hdr_a, 1'b0);
        send(p1, '1, 1'b1, 1'b0, '0, 1'b0);
        drain(60);
        rand_en = 1'b0;
        drain(4);
        compared++;
        if (q.size() !== 3) begin mismatched++; $display("FAIL b128_count: got %0d want 3", q.size()); end
        if (q.size() >= 3) begin
            compared++;
            if (q[0].d !== {p0[255:0], hdr_a} || q[0].k !== '1 || q[0].l !== 1'b0) begin
                mismatched++; $display("FAIL b128_beat0: got k=%h l=%b d=%h", q[0].k, q[0].l, q[0].d);
            end
            compared++;
            if (q[1].d !== {p1[255:0], p0[511:256]} || q[1].k !== '1 || q[1].l !== 1'b0) begin
                mismatched++; $display("FAIL b128_beat1: got k=%h l=%b d=%h", q[1].k, q[1].l, q[1].d);
            end
            compared++;
            if (q[2].d !== {256'h0, p1[511:256]} || q[2].k !== 64'h0000_0000_FFFF_FFFF || q[2].l !== 1'b1) begin
                mismatched++; $display("FAIL b128_beat2: got k=%h l=%b d=%h", q[2].k, q[2].l, q[2].d);
            end
        end
        compared++;
        if (stall_err !== 0) begin mismatched++; $display("FAIL b128_stall_stable: got %0d changes under stall, want 0", stall_err); end
    endtask

    task automatic test_hvalid_mid();
        logic [511:0] p0, p1;
        p0 = pat(8'h40);
        p1 = {256'h0, pat(8'hC0)};
        p1[511:256] = '0;
        q.delete();
        compared++;
        if (err_hdr !== 1'b0) begin mismatched++; $display("FAIL mid_err_before: got %b want 0", err_hdr); end
        send(p0, '1, 1'b0, 1'b1, hdr_b, 1'b0);
        send(p1, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, hdr_c, 1'b0);
        drain(6);
        compared++;
        if (q.size() !== 2) begin mismatched++; $display("FAIL mid_count: got %0d want 2", q.size()); end
        if (q.size() >= 2) begin
            compared++;
            if (q[1].d !== {p1[255:0], p0[511:256]} || q[1].k !== '1 || q[1].l !== 1'b1) begin
                mismatched++; $display("FAIL mid_beat1: got k=%h l=%b d=%h", q[1].k, q[1].l, q[1].d);
            end
        end
        compared++;
        if (err_hdr !== 1'b1) begin mismatched++; $display("FAIL mid_err_after: got %b want 1", err_hdr); end
    endtask

    task automatic test_sop_no_hvalid();
        do_reset();
        compared++;
        if (err_hdr !== 1'b0) begin mismatched++; $display("FAIL drop_err_before: got %b want 0", err_hdr); end
        send(pat(8'h01), '1, 1'b0, 1'b0, hdr_a, 1'b0);
        send(pat(8'h02), '1, 1'b1, 1'b0, '0, 1'b0);
        send('0, 64'h0, 1'b1, 1'b1, hdr_b, 1'b0);
        drain(6);
        compared++;
        if (q.size() !== 1) begin mismatched++; $display("FAIL drop_count: got %0d want 1", q.size()); end
        if (q.size() >= 1) begin
            compared++;
            if (q[0].d !== {256'h0, hdr_b} || q[0].k !== 64'h0000_0000_FFFF_FFFF || q[0].l !== 1'b1) begin
                mismatched++; $display("FAIL drop_next_pkt: got k=%h l=%b d=%h", q[0].k, q[0].l, q[0].d);
            end
        end
        compared++;
        if (err_hdr !== 1'b1) begin mismatched++; $display("FAIL drop_err_after: got %b want 1", err_hdr); end
    endtask

    task automatic test_reset_mid();
        ready_force = 1'b0;
        @(negedge clk);
        @(negedge clk);
        q.delete();
        send(pat(8'h20), '1, 1'b0, 1'b1, hdr_c, 1'b0);
        compared++;
        if (ib_rx.tvalid !== 1'b1) begin mismatched++; $display("FAIL rstmid_stalled: got tvalid %b want 1", ib_rx.tvalid); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (ib_rx.tvalid !== 1'b0) begin mismatched++; $display("FAIL rstmid_tvalid: got %b want 0", ib_rx.tvalid); end
        rst = 1'b0;
        ready_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        q.delete();
        send('0, 64'h0, 1'b1, 1'b1, hdr_a, 1'b0);
        drain(6);
        compared++;
        if (q.size() !== 1) begin mismatched++; $display("FAIL rstmid_count: got %0d want 1", q.size()); end
        if (q.size() >= 1) begin
            compared++;
            if (q[0].d !== {256'h0, hdr_a} || q[0].l !== 1'b1) begin
                mismatched++; $display("FAIL rstmid_next_pkt: got l=%b d=%h", q[0].l, q[0].d);
            end
        end
    endtask

    initial begin
        hdr_a = {8{32'hC0DE_0001}};
        hdr_b = {8{32'h1234_5678}};
        hdr_c = {8{32'hDEAD_BEEF}};
        test_reset();
        test_hdr_only();
        test_32b();
        test_64b();
        test_back_to_back_stall();
        test_hvalid_mid();
        test_sop_no_hvalid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
